rtc_time_formatter: RTL and testbench
=====================================

# rtc_time_formatter

Downstream stage between the DS1302 read path and the UART transmitter. Accepts one captured time triple (hour, minute and second registers in raw DS1302 BCD) and serialises it as an ASCII line, "HH:MM:SS\r\n", or "HH:MM:SS AM\r\n" / "HH:MM:SS PM\r\n" in 12-hour mode. It sends the line one byte at a time through the tx_module enable/done handshake. A one-deep pending buffer absorbs a new triple that arrives while a line is in flight.

## Interface
- SEPARATOR, 8'h3A, separator byte placed between fields (':').
- EMIT_CRLF, 1, 1 appends 8'h0D 8'h0A to each line; 0 omits both bytes.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- time_valid  in  1  one-cycle strobe; hour_bcd, min_bcd and sec_bcd are valid in the same cycle.
- hour_bcd  in  8  DS1302 hour register: bit7 = 12h mode, bit5 = PM (12h mode) or tens bit1 (24h mode).
- min_bcd  in  8  DS1302 minute register; bit7 is ignored.
- sec_bcd  in  8  DS1302 second register; bit7 (CH) is ignored.
- tx_en_sig  out  1  request to tx_module; held high until tx_done.
- tx_data  out  8  byte to transmit; stable while tx_en_sig is high.
- tx_done  in  1  one-cycle completion pulse from tx_module.
- busy  out  1  high while a line is active or a triple is pending.
- drop_cnt  out  8  count of overwritten pending triples; saturates at 255.

## Operation
- Digit extraction:
  - Seconds: tens = sec[6:4], units = sec[3:0].
  - Minutes: tens = min[6:4], units = min[3:0].
  - Hours, 24h mode: tens = hour[5:4].
  - Hours, 12h mode: tens = {1'b0, hour[4]}.
- ASCII mapping: digit d ≤ 9 maps to 8'h30 + d. Any nibble > 9 maps to '?' (8'h3F); no other checking is done.
- Line length:
  - 24h mode: 8 bytes, plus 2 if EMIT_CRLF (10 total).
  - 12h mode: adds " AM" or " PM" (8'h20, 8'h41/8'h50, 8'h4D) before the CRLF (13 total with CRLF).
- Mode and AM/PM are latched with the triple; they cannot change mid-line.
- Registers: active triple, pending triple + pend_valid, char_idx (4 bits), state.
- States:
  - IDLE: busy=0, tx_en_sig=0.
    - time_valid → latch into active, char_idx=0, tx_en_sig<=1 → SEND.
  - SEND: tx_data = char(char_idx).
    - tx_done with char_idx = last → tx_en_sig<=0 → FIN.
    - tx_done otherwise → tx_en_sig<=0, char_idx++ → GAP.
  - GAP: one cycle with tx_en_sig=0; then tx_en_sig<=1 → SEND.
  - FIN:
    - pend_valid=1 → pending copied to active, pend_valid<=0, char_idx=0, tx_en_sig<=1 → SEND.
    - Else if time_valid → latch directly into active → SEND.
    - Else → IDLE.
- time_valid in SEND/GAP, or in FIN while pend_valid=1:
  - Writes the pending buffer and sets pend_valid.
  - If pend_valid was already 1 and is not being consumed that cycle, the old pending is overwritten and drop_cnt increments (saturating).
  - In FIN with pend_valid=1, the old pending moves to active and the new triple becomes pending; no drop is counted.
- tx_done outside SEND is ignored.

## Timing
- Reset values:
  - tx_en_sig=0, tx_data=8'h00, busy=0, drop_cnt=0.
  - State IDLE, pend_valid=0.
- Assertion of rst_n mid-line aborts the line immediately and clears pending; no partial-line resume.
- Latency:
  - time_valid at cycle N (IDLE) → tx_en_sig=1 with first byte at N+1.
  - tx_done at cycle M → tx_en_sig=0 at M+1 → next byte with tx_en_sig=1 at M+2.
  - Last tx_done at M → FIN at M+1 → IDLE at M+2 (busy=0 at M+2), or next line's first byte at M+2 if pending.
- tx_data changes only while tx_en_sig is low, or on the same edge that raises it.
- busy is registered: high from N+1 until IDLE is re-entered.

## Test plan
- 24h line: hour=8'h23, min=8'h59, sec=8'h58, tx_done 20 cycles after each tx_en_sig rise.
  - Required bytes: 32 33 3A 35 39 3A 35 38 0D 0A.
  - busy then drops; drop_cnt=0.
- 12h line with CH set: hour=8'hB1, min=8'h05, sec=8'h85.
  - Required bytes: 31 31 3A 30 35 3A 30 35 20 50 4D 0D 0A.
- Back-to-back: second triple during byte 3 of the first line, third triple during byte 5.
  - Exactly two lines, the second carrying the third triple; drop_cnt=1.
  - The second line's first byte has tx_en_sig rising 2 cycles after the first line's final tx_done.
- Invalid BCD: min=8'h5C → minute field 35 3F. EMIT_CRLF=0 → 8-byte line.
- Reset mid-line: rst_n low during byte 4 with a triple pending.
  - tx_en_sig=0 and busy=0 immediately; no further bytes after release until a new time_valid.
- Stray tx_done in IDLE/GAP causes no state change; drop_cnt saturates at 255 after 300 forced overwrites.

Source files
------------

// File: rtl/rtc_time_formatter.sv
// rtc_time_formatter: serialises a DS1302 BCD time triple as an ASCII line over the tx_module enable/done handshake.
module rtc_time_formatter #(
  parameter logic [7:0] SEPARATOR = 8'h3A,
  parameter bit         EMIT_CRLF = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       time_valid,
  input  logic [7:0] hour_bcd,
  input  logic [7:0] min_bcd,
  input  logic [7:0] sec_bcd,
  output logic       tx_en_sig,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  output logic       busy,
  output logic [7:0] drop_cnt
);
  typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;
  state_t      state_q, state_d;
  logic [23:0] act_q, act_d, pend_q, pend_d;
  logic        pend_valid_q, pend_valid_d;
  logic [3:0]  char_idx_q, char_idx_d;
  logic        tx_en_q, tx_en_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;
  logic [23:0] trip;
  logic        last;
  logic        pend_wr;
  assign trip = {hour_bcd, min_bcd, sec_bcd};
  function automatic logic [7:0] asc(input logic [3:0] d);
    return (d > 4'd9) ? 8'h3F : 8'h30 + {4'd0, d};
  endfunction
  // Triple layout is {hour, min, sec}; hour bit7 selects 12h mode, which adds " AM"/" PM".
  function automatic logic [3:0] last_idx(input logic [23:0] t);
    return (t[23] ? 4'd10 : 4'd7) + (EMIT_CRLF ? 4'd2 : 4'd0);
  endfunction
  function automatic logic [7:0] char_of(input logic [23:0] t, input logic [3:0] i);
    logic [3:0] base;
    logic [7:0] c;
    base = t[23] ? 4'd11 : 4'd8;
    case (i)
      4'd0:    c = asc(t[23] ? {3'd0, t[20]} : {2'd0, t[21:20]});
      4'd1:    c = asc(t[19:16]);
      4'd3:    c = asc({1'b0, t[14:12]});
      4'd4:    c = asc(t[11:8]);
      4'd6:    c = asc({1'b0, t[6:4]});
      4'd7:    c = asc(t[3:0]);
      4'd8:    c = 8'h20;
      4'd9:    c = t[21] ? 8'h50 : 8'h41;
      4'd10:   c = 8'h4D;
      default: c = SEPARATOR;
    endcase
    if (i >= base) c = (i == base) ? 8'h0D : 8'h0A;
    return c;
  endfunction
  assign last = char_idx_q == last_idx(act_q);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      act_q        <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      char_idx_q   <= '0;
      tx_en_q      <= 1'b0;
      tx_data_q    <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      act_q        <= act_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      char_idx_q   <= char_idx_d;
      tx_en_q      <= tx_en_d;
      tx_data_q    <= tx_data_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = time_valid ? SEND : IDLE;
      SEND:    state_d = tx_done ? (last ? FIN : GAP) : SEND;
      GAP:     state_d = SEND;
      FIN:     state_d = (pend_valid_q || time_valid) ? SEND : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // A new triple goes to the pending slot whenever the active line cannot take it.
  assign pend_wr = time_valid && (state_q == SEND || state_q == GAP || (state_q == FIN && pend_valid_q));
  always_comb begin
    act_d        = act_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    char_idx_d   = char_idx_q;
    tx_en_d      = tx_en_q;
    drop_cnt_d   = drop_cnt_q;
    case (state_q)
      IDLE: if (time_valid) begin
        act_d      = trip;
        char_idx_d = '0;
        tx_en_d    = 1'b1;
      end
      SEND: if (tx_done) begin
        tx_en_d    = 1'b0;
        char_idx_d = char_idx_q + 4'd1;
      end
      GAP: tx_en_d = 1'b1;
      FIN: if (pend_valid_q || time_valid) begin
        act_d        = pend_valid_q ? pend_q : trip;
        pend_valid_d = 1'b0;
        char_idx_d   = '0;
        tx_en_d      = 1'b1;
      end
      default: tx_en_d = 1'b0;
    endcase
    if (pend_wr) begin
      pend_d       = trip;
      pend_valid_d = 1'b1;
      drop_cnt_d   = (pend_valid_q && state_q != FIN && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
    end
    tx_data_d = (tx_en_d && !tx_en_q) ? char_of(act_d, char_idx_d) : tx_data_q;
  end
  assign tx_en_sig = tx_en_q;
  assign tx_data   = tx_data_q;
  assign busy      = state_q != IDLE;
  assign drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_rtc_time_formatter.sv
// tb_rtc_time_formatter: scoreboard bench; a tx_module responder pops expected bytes as each one is offered.
module tb_rtc_time_formatter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic       time_valid = 1'b0;
  logic [7:0] hour_bcd = '0, min_bcd = '0, sec_bcd = '0;
  logic       tx_en_sig, busy;
  logic [7:0] tx_data, drop_cnt;
  logic       resp_done = 1'b0, stray_done = 1'b0, tx_done;
  assign tx_done = resp_done | stray_done;
  logic       tv2 = 1'b0, done2 = 1'b0;
  logic [7:0] h2 = '0, m2 = '0, s2 = '0;
  logic       en2, busy2;
  logic [7:0] data2, drop2;
  rtc_time_formatter dut (
    .clk(clk), .rst_n(rst_n), .time_valid(time_valid), .hour_bcd(hour_bcd), .min_bcd(min_bcd),
    .sec_bcd(sec_bcd), .tx_en_sig(tx_en_sig), .tx_data(tx_data), .tx_done(tx_done), .busy(busy),
    .drop_cnt(drop_cnt));
  rtc_time_formatter #(.EMIT_CRLF(1'b0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .time_valid(tv2), .hour_bcd(h2), .min_bcd(m2),
    .sec_bcd(s2), .tx_en_sig(en2), .tx_data(data2), .tx_done(done2), .busy(busy2),
    .drop_cnt(drop2));
  typedef struct {
    logic [7:0] b;
    bit         ch;
  } exp_t;
  exp_t       q[$];
  int         n_checks = 0, n_fail = 0, cyc = 0, done_cyc = 0, rx_count = 0;
  int         dly = 21, last_len = 0, exp_drop = 0, idle_cyc = 0;
  bit         stray_gap = 1'b0;
  logic [7:0] lb[13];
  int         ln;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask
  function automatic logic [7:0] asc(input logic [3:0] d);
    return (d < 4'd10) ? (8'h30 | {4'h0, d}) : 8'h3F;
  endfunction
  task automatic build(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input bit crlf);
    logic [3:0] ht;
    ht = h[7] ? {3'b0, h[4]} : {2'b0, h[5:4]};
    lb[0] = asc(ht);  lb[1] = asc(h[3:0]);  lb[2] = 8'h3A;
    lb[3] = asc({1'b0, m[6:4]});  lb[4] = asc(m[3:0]);  lb[5] = 8'h3A;
    lb[6] = asc({1'b0, s[6:4]});  lb[7] = asc(s[3:0]);
    ln = 8;
    if (h[7]) begin
      lb[8] = 8'h20;  lb[9] = h[5] ? 8'h50 : 8'h41;  lb[10] = 8'h4D;
      ln = 11;
    end
    if (crlf) begin
      lb[ln] = 8'h0D;  lb[ln+1] = 8'h0A;
      ln += 2;
    end
  endtask
  // kind 0: starts from idle, 1: becomes pending, 2: overwrites the pending triple
  task automatic drive(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input int kind);
    exp_t e;
    build(h, m, s, 1'b1);
    if (kind == 2) begin
      repeat (last_len) e = q.pop_back();
      if (exp_drop < 255) exp_drop++;
    end
    for (int i = 0; i < ln; i++) begin
      e.b = lb[i];
      e.ch = (i > 0) || (kind != 0);
      q.push_back(e);
    end
    last_len = ln;
    hour_bcd = h;  min_bcd = m;  sec_bcd = s;  time_valid = 1'b1;
    @(negedge clk);
    time_valid = 1'b0;
    if (kind == 0) begin
      check("start_en", tx_en_sig, 1);
      check("start_busy", busy, 1);
    end
  endtask
  task automatic wait_idle(input int limit);
    int k = 0;
    while (busy && k < limit) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", busy, 0);
    idle_cyc = cyc;
  endtask
  task automatic wait_bytes(input int target, input int limit);
    int k = 0;
    while (rx_count < target && k < limit) begin
      @(negedge clk);
      k++;
    end
    check("bytes_timeout", rx_count >= target, 1);
  endtask
  int         cnt = 0;
  bit         held = 1'b0;
  exp_t       cur;
  initial begin
    forever begin
      @(negedge clk);
      if (resp_done && stray_gap && !held) held = 1'b1;
      else begin
        resp_done = 1'b0;
        held = 1'b0;
      end
      if (!rst_n || !tx_en_sig) cnt = 0;
      else begin
        if (cnt == 0) begin
          rx_count++;
          check("sb_nonempty", q.size() != 0, 1);
          if (q.size() != 0) begin
            cur = q.pop_front();
            check("byte", tx_data, cur.b);
            if (cur.ch) check("byte_gap", cyc - done_cyc, 2);
          end
        end else check("data_stable", tx_data, cur.b);
        cnt++;
        if (cnt == dly) begin
          resp_done = 1'b1;
          cnt = 0;
          done_cyc = cyc;
        end
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int base;
    logic [7:0] sv;
    repeat (3) @(negedge clk);
    check("rst_en", tx_en_sig, 0);
    check("rst_data", tx_data, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_en_nc", en2, 0);
    rst_n = 1'b1;
    @(negedge clk);
    drive(8'h23, 8'h59, 8'h58, 0);
    wait_idle(400);
    check("busy_fall", idle_cyc - done_cyc, 2);
    check("drop_24h", drop_cnt, 0);
    check("sb_24h", q.size(), 0);
    stray_gap = 1'b1;
    drive(8'hB1, 8'h05, 8'h85, 0);
    wait_idle(400);
    stray_gap = 1'b0;
    check("sb_12h", q.size(), 0);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    check("stray_idle_busy", busy, 0);
    check("stray_idle_en", tx_en_sig, 0);
    base = rx_count;
    drive(8'h12, 8'h34, 8'h56, 0);
    wait_bytes(base + 3, 200);
    drive(8'h01, 8'h02, 8'h03, 1);
    wait_bytes(base + 5, 200);
    drive(8'h92, 8'h41, 8'h07, 2);
    check("drop_b2b", drop_cnt, exp_drop);
    wait_idle(1000);
    check("b2b_count", rx_count - base, 23);
    check("sb_b2b", q.size(), 0);
    build(8'h12, 8'h5C, 8'h07, 1'b0);
    h2 = 8'h12;  m2 = 8'h5C;  s2 = 8'h07;  tv2 = 1'b1;
    @(negedge clk);
    tv2 = 1'b0;
    for (int i = 0; i < ln; i++) begin
      int k = 0;
      while (!en2 && k < 50) begin
        @(negedge clk);
        k++;
      end
      check("nc_en", en2, 1);
      check("nc_byte", data2, lb[i]);
      repeat (3) @(negedge clk);
      done2 = 1'b1;
      @(negedge clk);
      done2 = 1'b0;
    end
    repeat (4) @(negedge clk);
    check("nc_len_en", en2, 0);
    check("nc_len_busy", busy2, 0);
    base = rx_count;
    drive(8'h07, 8'h30, 8'h15, 0);
    wait_bytes(base + 4, 200);
    drive(8'h08, 8'h31, 8'h16, 1);
    rst_n = 1'b0;
    #1;
    check("abort_en", tx_en_sig, 0);
    check("abort_busy", busy, 0);
    check("abort_drop", drop_cnt, 0);
    q.delete();
    last_len = 0;
    exp_drop = 0;
    @(negedge clk);
    rst_n = 1'b1;
    base = rx_count;
    repeat (60) @(negedge clk);
    check("no_resume", rx_count - base, 0);
    check("no_resume_busy", busy, 0);
    dly = 41;
    drive(8'h10, 8'h20, 8'h30, 0);
    for (int i = 0; i <= 300; i++) begin
      sv = {4'(((i % 60) / 10)), 4'((i % 60) % 10)};
      drive(8'h01, 8'h02, sv, (i == 0) ? 1 : 2);
      if (i == 100) check("drop_100", drop_cnt, exp_drop);
    end
    check("drop_sat", drop_cnt, exp_drop);
    check("drop_sat_abs", drop_cnt, 255);
    wait_idle(2000);
    check("sb_final", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
